// File: rtl/sump_cmd_ctrl.sv
// SUMP command decoder: config registers, core sequencing and ID responder, with a one-entry holding buffer.
// Define LOGIP_XON_XOFF_EN to add the tx_pause_o port and XON/XOFF (0x11/0x13) handling.
module sump_cmd_ctrl #(
    parameter int          DATA_BITS       = 8,
    parameter int          CMD_WIDTH_WORDS = 5,
    parameter int          TRIG_STAGES     = 4,
    parameter logic [31:0] ID_WORD         = 32'h534C_4131
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [DATA_BITS*CMD_WIDTH_WORDS-1:0] cmd_i,
    input  logic                                 stb_i,
    output logic [32*TRIG_STAGES-1:0]            trig_mask_o,
    output logic [32*TRIG_STAGES-1:0]            trig_val_o,
    output logic [32*TRIG_STAGES-1:0]            trig_cfg_o,
    output logic [23:0]                          divider_o,
    output logic [15:0]                          read_cnt_o,
    output logic [15:0]                          delay_cnt_o,
    output logic [7:0]                           flags_o,
    output logic                                 soft_rst_o,
    output logic                                 armed_o,
    input  logic                                 done_i,
    output logic [7:0]                           tx_data_o,
    output logic                                 tx_valid_o,
    input  logic                                 tx_ready_i,
`ifdef LOGIP_XON_XOFF_EN
    output logic                                 tx_pause_o,
`endif
    output logic                                 ovf_o
);
    localparam int CW = DATA_BITS * CMD_WIDTH_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SEND_ID} state_t;

    state_t                         r_state, w_next;
    logic [CW-1:0]                  r_cmd_q, r_buf;
    logic                           r_buf_full, r_ovf, r_armed, r_soft_rst;
    logic [1:0]                     r_idx;
    logic [TRIG_STAGES-1:0][31:0]   r_mask, r_val, r_cfg;
    logic [23:0]                    r_div;
    logic [15:0]                    r_rd, r_dl;
    logic [7:0]                     r_flags;

    logic        w_stb, w_pause, w_exec, w_long, w_is_id, w_is_rst, w_is_run;
    logic        w_tx_fire, w_id_done, w_consume, w_from_buf, w_from_in, w_take;
    logic [7:0]  w_op, w_sop;
    logic [31:0] w_pay;

    assign w_exec   = (r_state == S_EXEC);
    assign w_long   = r_cmd_q[7];
    assign w_op     = r_cmd_q[7:0];
    assign w_pay    = r_cmd_q[39:8];
    assign w_sop    = r_cmd_q[39:32];
    assign w_is_rst = w_exec && !w_long && (w_sop == 8'h00);
    assign w_is_run = w_exec && !w_long && (w_sop == 8'h01);
    assign w_is_id  = w_exec && !w_long && (w_sop == 8'h02);

`ifdef LOGIP_XON_XOFF_EN
    // Flow control acts at strobe time so XON can reach us while SEND_ID is stalled.
    logic r_pause, w_xon, w_xoff;
    assign w_xoff  = stb_i && !cmd_i[7] && (cmd_i[39:32] == 8'h13);
    assign w_xon   = stb_i && !cmd_i[7] && (cmd_i[39:32] == 8'h11);
    assign w_stb   = stb_i && !w_xon && !w_xoff;
    assign w_pause = r_pause;
    assign tx_pause_o = r_pause;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         r_pause <= 1'b0;
        else if (w_is_rst) r_pause <= 1'b0;
        else if (w_xoff)   r_pause <= 1'b1;
        else if (w_xon)    r_pause <= 1'b0;
    end
`else
    assign w_stb   = stb_i;
    assign w_pause = 1'b0;
`endif

    assign tx_valid_o = (r_state == S_SEND_ID) && !w_pause;
    assign tx_data_o  = tx_valid_o ? ID_WORD[{r_idx, 3'b000} +: 8] : 8'h00;
    assign w_tx_fire  = tx_valid_o && tx_ready_i;
    assign w_id_done  = w_tx_fire && (r_idx == 2'd3);

    // Points where a new command may enter cmd_q; a pending buffer entry has priority.
    assign w_consume  = (r_state == S_IDLE) || (w_exec && !w_is_id) || w_id_done;
    assign w_from_buf = w_consume && r_buf_full;
    assign w_from_in  = w_consume && !r_buf_full && w_stb;
    assign w_take     = w_from_buf || w_from_in;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_take) w_next = S_EXEC;
            S_EXEC:    w_next = w_is_id ? S_SEND_ID : (w_take ? S_EXEC : S_IDLE);
            S_SEND_ID: if (w_id_done) w_next = w_take ? S_EXEC : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cmd_q    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_ovf      <= 1'b0;
            r_idx      <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_from_buf)     r_cmd_q <= r_buf;
            else if (w_from_in) r_cmd_q <= cmd_i;
            if (w_stb && !r_buf_full && !w_from_in) begin
                r_buf      <= cmd_i;
                r_buf_full <= 1'b1;
            end else if (w_from_buf) begin
                r_buf_full <= 1'b0;
            end
            if (w_stb && r_buf_full) r_ovf <= 1'b1;
            if (r_state != S_SEND_ID) r_idx <= 2'd0;
            else if (w_tx_fire)       r_idx <= r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mask <= '0; r_val <= '0; r_cfg <= '0;
            r_div <= '0; r_rd <= '0; r_dl <= '0; r_flags <= '0;
            r_soft_rst <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_soft_rst <= w_is_rst;
            // Run beats a coincident done_i.
            if (w_is_run)                 r_armed <= 1'b1;
            else if (w_is_rst || done_i)  r_armed <= 1'b0;
            if (w_is_rst) begin
                r_mask <= '0; r_val <= '0; r_cfg <= '0;
                r_div <= '0; r_rd <= '0; r_dl <= '0; r_flags <= '0;
            end else if (w_exec && w_long) begin
                for (int s = 0; s < TRIG_STAGES; s++) begin
                    if (w_op[7:4] == 4'hC && w_op[3:2] == 2'(s)) begin
                        case (w_op[1:0])
                            2'd0:    r_mask[s] <= w_pay;
                            2'd1:    r_val[s]  <= w_pay;
                            2'd2:    r_cfg[s]  <= w_pay;
                            default: ;
                        endcase
                    end
                end
                case (w_op)
                    8'h80:   r_div <= w_pay[23:0];
                    8'h81:   begin r_rd <= w_pay[15:0]; r_dl <= w_pay[31:16]; end
                    8'h82:   r_flags <= w_pay[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign trig_mask_o = r_mask;
    assign trig_val_o  = r_val;
    assign trig_cfg_o  = r_cfg;
    assign divider_o   = r_div;
    assign read_cnt_o  = r_rd;
    assign delay_cnt_o = r_dl;
    assign flags_o     = r_flags;
    assign soft_rst_o  = r_soft_rst;
    assign armed_o     = r_armed;
    assign ovf_o       = r_ovf;
endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// Scoreboarded bench for sump_cmd_ctrl: command-level reference model, tx/soft-reset monitor.
module tb_sump_cmd_ctrl;
    localparam int TS = 4;

    logic            clk = 1'b0, rst, stb, done, tx_ready;
    logic [39:0]     cmd;
    logic [32*TS-1:0] trig_mask, trig_val, trig_cfg;
    logic [23:0]     divider;
    logic [15:0]     read_cnt, delay_cnt;
    logic [7:0]      flags, tx_data;
    logic            soft_rst, armed, tx_valid, ovf;
`ifdef LOGIP_XON_XOFF_EN
    logic            tx_pause;
`endif

    sump_cmd_ctrl #(.DATA_BITS(8), .CMD_WIDTH_WORDS(5), .TRIG_STAGES(TS), .ID_WORD(32'h534C_4131)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_i(cmd), .stb_i(stb),
        .trig_mask_o(trig_mask), .trig_val_o(trig_val), .trig_cfg_o(trig_cfg),
        .divider_o(divider), .read_cnt_o(read_cnt), .delay_cnt_o(delay_cnt), .flags_o(flags),
        .soft_rst_o(soft_rst), .armed_o(armed), .done_i(done),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
`ifdef LOGIP_XON_XOFF_EN
        .tx_pause_o(tx_pause),
`endif
        .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [7:0] exp_tx[$];
    int exp_soft = 0;
    bit rnd_rdy = 0;

    // Reference model state
    logic [31:0] m_mask[TS], m_val[TS], m_cfg[TS];
    logic [23:0] m_div;
    logic [15:0] m_rd, m_dl;
    logic [7:0]  m_flags;
    logic        m_armed, m_ovf, m_pause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_clear_cfg();
        for (int s = 0; s < TS; s++) begin m_mask[s] = 0; m_val[s] = 0; m_cfg[s] = 0; end
        m_div = 0; m_rd = 0; m_dl = 0; m_flags = 0;
    endfunction

    function automatic void model_apply(input logic [39:0] c);
        logic [7:0] op;
        logic [31:0] p;
        int s;
        if (c[7]) begin
            op = c[7:0];
            p  = c[39:8];
            s  = int'(op[3:2]);
            if (op[7:4] == 4'hC) begin
                if (s < TS) begin
                    if (op[1:0] == 2'd0) m_mask[s] = p;
                    if (op[1:0] == 2'd1) m_val[s]  = p;
                    if (op[1:0] == 2'd2) m_cfg[s]  = p;
                end
            end else if (op == 8'h80) m_div = p[23:0];
            else if (op == 8'h81) begin m_rd = p[15:0]; m_dl = p[31:16]; end
            else if (op == 8'h82) m_flags = p[7:0];
        end else begin
            case (c[39:32])
                8'h00: begin model_clear_cfg(); m_armed = 0; m_pause = 0; exp_soft++; end
                8'h01: m_armed = 1;
                8'h02: begin
                    // "1ALS"
                    exp_tx.push_back(8'h31); exp_tx.push_back(8'h41);
                    exp_tx.push_back(8'h4C); exp_tx.push_back(8'h53);
                end
`ifdef LOGIP_XON_XOFF_EN
                8'h13: m_pause = 1;
                8'h11: m_pause = 0;
`endif
                default: ;
            endcase
        end
    endfunction

    task automatic check_all(input string tag);
        for (int s = 0; s < TS; s++) begin
            chk($sformatf("%s_mask%0d", tag, s), trig_mask[32*s +: 32], m_mask[s]);
            chk($sformatf("%s_val%0d", tag, s),  trig_val[32*s +: 32],  m_val[s]);
            chk($sformatf("%s_cfg%0d", tag, s),  trig_cfg[32*s +: 32],  m_cfg[s]);
        end
        chk({tag, "_div"},   32'(divider),   32'(m_div));
        chk({tag, "_rd"},    32'(read_cnt),  32'(m_rd));
        chk({tag, "_dl"},    32'(delay_cnt), 32'(m_dl));
        chk({tag, "_flags"}, 32'(flags),     32'(m_flags));
        chk({tag, "_armed"}, 32'(armed),     32'(m_armed));
        chk({tag, "_ovf"},   32'(ovf),       32'(m_ovf));
`ifdef LOGIP_XON_XOFF_EN
        chk({tag, "_pause"}, 32'(tx_pause),  32'(m_pause));
`endif
    endtask

    function automatic logic [39:0] lcmd(input logic [7:0] op, input logic [31:0] p);
        return {p, op};
    endfunction

    function automatic logic [39:0] scmd(input logic [7:0] op);
        logic [31:0] r;
        r = $urandom;
        return {op, r[23:0], 1'b0, r[30:24]};
    endfunction

    // All stimulus runs at posedge+1.
    task automatic strobe(input logic [39:0] c);
        cmd = c; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_tx.size() != 0; i++) idle(1);
        chk("tx_drain_left", exp_tx.size(), 0);
        idle(2);
    endtask

    // Monitor: scoreboard for tx handshakes and soft-reset pulses, plus hold stability.
    logic pv = 0, pacc = 0;
    logic [7:0] pd = 0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 0;
        end else begin
            if (pv && !pacc) begin
                checks++;
                if (!tx_valid || tx_data !== pd) begin
                    failures++;
                    $display("FAIL tx_hold actual=%0b/%0h required=1/%0h", tx_valid, tx_data, pd);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    if (tx_data !== e) begin
                        failures++;
                        $display("FAIL tx_byte actual=%0h required=%0h", tx_data, e);
                    end
                end
            end
            if (soft_rst) begin
                checks++;
                if (exp_soft == 0) begin
                    failures++;
                    $display("FAIL soft_rst_unexpected actual=1 required=0");
                end else exp_soft--;
            end
            pv = tx_valid; pd = tx_data; pacc = tx_ready;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) tx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [39:0] c;
        int k;
        rst = 1; stb = 0; cmd = 0; done = 0; tx_ready = 0;
        model_clear_cfg(); m_armed = 0; m_ovf = 0; m_pause = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle(1);
        check_all("reset");
        chk("reset_soft", 32'(soft_rst), 0);
        chk("reset_txv", 32'(tx_valid), 0);
        chk("reset_txd", 32'(tx_data), 0);

        strobe(lcmd(8'hC4, 32'hDEADBEEF)); model_apply(lcmd(8'hC4, 32'hDEADBEEF));
        idle(2);
        check_all("c4");

        // Latency: new value only after the second edge
        strobe(lcmd(8'h81, 32'h0010_0020));
        chk("rd_early", 32'(read_cnt), 0);
        model_apply(lcmd(8'h81, 32'h0010_0020));
        idle(1);
        chk("rd_lat", 32'(read_cnt), 32'h20);
        chk("dl_lat", 32'(delay_cnt), 32'h10);

        strobe(scmd(8'h00));
        chk("soft_pre", 32'(soft_rst), 0);
        model_apply(scmd(8'h00));
        idle(1);
        chk("soft_hi", 32'(soft_rst), 1);
        idle(1);
        chk("soft_lo", 32'(soft_rst), 0);
        check_all("after_rstcmd");

        // ID with toggling ready
        strobe(scmd(8'h02)); model_apply(scmd(8'h02));
        for (int i = 0; i < 12; i++) begin tx_ready = (i % 2 == 0); idle(1); end
        tx_ready = 0;
        wait_drain(20);

        // Overflow while SEND_ID is stalled
        strobe(scmd(8'h02)); model_apply(scmd(8'h02));
        idle(1);
        strobe(lcmd(8'h80, 32'h0000_0064)); model_apply(lcmd(8'h80, 32'h0000_0064));
        strobe(lcmd(8'h80, 32'h0000_0099));
        strobe(lcmd(8'h82, 32'h0000_00EE));
        m_ovf = 1;
        chk("ovf_set", 32'(ovf), 1);
        chk("div_held", 32'(divider), 0);
        tx_ready = 1;
        wait_drain(20);
        tx_ready = 0;
        check_all("ovf");

        // Back-to-back strobes
        cmd = lcmd(8'h82, 32'h5A); stb = 1; idle(1);
        cmd = lcmd(8'h80, 32'h1234); idle(1);
        stb = 0;
        model_apply(lcmd(8'h82, 32'h5A));
        chk("b2b_first", 32'(flags), 32'h5A);
        chk("b2b_second_early", 32'(divider), 32'h64);
        idle(1);
        model_apply(lcmd(8'h80, 32'h1234));
        chk("b2b_second", 32'(divider), 32'h1234);

        // Arm / done
        strobe(scmd(8'h01)); model_apply(scmd(8'h01));
        idle(1);
        chk("armed_set", 32'(armed), 1);
        done = 1; idle(1); done = 0; m_armed = 0;
        chk("armed_clr", 32'(armed), 0);
        strobe(scmd(8'h01)); model_apply(scmd(8'h01));
        done = 1; idle(1); done = 0;
        chk("armed_race", 32'(armed), 1);
        check_all("arm");

`ifdef LOGIP_XON_XOFF_EN
        tx_ready = 1;
        strobe(scmd(8'h13)); model_apply(scmd(8'h13));
        chk("xoff", 32'(tx_pause), 1);
        strobe(scmd(8'h02)); model_apply(scmd(8'h02));
        idle(4);
        chk("paused_txv", 32'(tx_valid), 0);
        chk("paused_left", exp_tx.size(), 4);
        strobe(scmd(8'h11)); model_apply(scmd(8'h11));
        wait_drain(20);
        tx_ready = 0;
        check_all("xon");
`endif

        // Random commands
        rnd_rdy = 1;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            c = {32'($urandom), 8'($urandom)};
            if (k <= 4)      c[7:4] = 4'hC;
            else if (k == 5) c[7:0] = 8'h80 + 8'($urandom_range(0, 2));
            else if (k == 6) c[7:0] = 8'h83 + 8'($urandom_range(0, 124));
            else if (k == 7) c = scmd(8'($urandom_range(0, 2)));
            else if (k == 8) begin
                c = scmd(8'($urandom_range(3, 255)));
                if (c[39:32] == 8'h11 || c[39:32] == 8'h13) c[39:32] = 8'h20;
            end else c = scmd(8'h02);
            strobe(c); model_apply(c);
            idle(2);
            wait_drain(40);
            if ($urandom_range(0, 4) == 0) begin
                done = 1; idle(1); done = 0; m_armed = 0;
            end
            check_all($sformatf("rnd%0d", n));
        end
        rnd_rdy = 0;
        idle(1);
        tx_ready = 0;

        // Reset in the middle of SEND_ID
        strobe(scmd(8'h02)); model_apply(scmd(8'h02));
        idle(2);
        chk("mid_txv_pre", 32'(tx_valid), 1);
        #2 rst = 1;
        #1 chk("mid_txv_async", 32'(tx_valid), 0);
        exp_tx.delete();
        model_clear_cfg(); m_armed = 0; m_ovf = 0; m_pause = 0;
        @(posedge clk); #1 rst = 0;
        tx_ready = 1;
        idle(8);
        tx_ready = 0;
        check_all("midrst");
        chk("end_tx_left", exp_tx.size(), 0);
        chk("end_soft_left", 32'(exp_soft), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
